// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: FSM states, game presets and time constants shared by chess_clock.
package chess_clock_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} clk_state_t;
    localparam int CS_PER_SEC = 100;
    localparam int CS_PER_MIN = 6000;
    localparam int PRESET_CS [4] = '{6000, 18000, 60000, 180000};
    localparam int PRESET_INC_CS [4] = '{0, 200, 500, 0};
endpackage

// File: rtl/chess_clock_if.sv
// chess_clock_if: control pulses, selects, timers, status and 7-seg outputs of chess_clock.
interface chess_clock_if #(parameter int N_PLAYERS = 2, parameter int TIME_W = 18);
    localparam int PW = $clog2(N_PLAYERS);
    logic start, pause, move_done;
    logic [1:0] mode_sel;
    logic [PW-1:0] disp_sel, active_player, loser;
    logic [N_PLAYERS*TIME_W-1:0] time_cs;
    logic running, time_up;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    modport master (output start, pause, move_done, mode_sel, disp_sel,
                    input time_cs, active_player, running, time_up, loser,
                    hex0, hex1, hex2, hex3, hex4, hex5);
    modport slave (input start, pause, move_done, mode_sel, disp_sel,
                   output time_cs, active_player, running, time_up, loser,
                   hex0, hex1, hex2, hex3, hex4, hex5);
endinterface

// File: rtl/hex_display.sv
// hex_display: 4-bit value to active-low 7-segment pattern ordered {g,f,e,d,c,b,a}.
module hex_display (
    input  logic [3:0] val,
    output logic [6:0] seg
);
    always_comb
        case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'ha: seg = 7'h08;
            4'hb: seg = 7'h03;
            4'hc: seg = 7'h46;
            4'hd: seg = 7'h21;
            4'he: seg = 7'h06;
            default: seg = 7'h0e;
        endcase
endmodule

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every DIV enabled cycles; clr restarts the count at 0.
module tick_divider #(parameter int DIV = 500_000) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == CW'(DIV - 1);
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/chess_clock.sv
// chess_clock: multi-player countdown chess clock with MM:SS:cc 7-seg view.
// Define CHESS_CLOCK_INCREMENT_EN to add the Fischer increment on move_done.
module chess_clock import chess_clock_pkg::*; #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int N_PLAYERS   = 2,
    parameter int TIME_W      = 18
) (
    input logic clk,
    input logic reset_n,
    chess_clock_if.slave bus
);
    localparam int PW = $clog2(N_PLAYERS);
    localparam logic [TIME_W-1:0] T_MAX = '1;
    clk_state_t state_q, state_d;
    logic [TIME_W-1:0] time_q [N_PLAYERS];
    logic [TIME_W-1:0] time_d [N_PLAYERS];
    logic [PW-1:0] act_q, act_d, loser_q, loser_d;
    logic time_up_q, time_up_d;
    logic run, tick, expire;
    logic [TIME_W-1:0] preset, cur, cur_dec, mv_t;
    assign run = state_q == RUN;
    assign preset = TIME_W'(PRESET_CS[bus.mode_sel]);
    assign cur = time_q[act_q];
    assign cur_dec = tick ? cur - 1'b1 : cur;
    assign expire = tick && cur == TIME_W'(1);

    tick_divider #(.DIV(CLK_FREQ_HZ / TICK_HZ)) u_div (
        .clk(clk), .reset_n(reset_n), .en(run),
        .clr(bus.start || (run && bus.move_done)), .tick(tick));

`ifdef CHESS_CLOCK_INCREMENT_EN
    // Increment follows the mode latched at start, not the live mode_sel.
    logic [1:0] mode_q, mode_d;
    logic [TIME_W-1:0] inc;
    logic [TIME_W:0] sum;
    assign mode_d = bus.start ? bus.mode_sel : mode_q;
    assign inc = TIME_W'(PRESET_INC_CS[mode_q]);
    assign sum = {1'b0, cur_dec} + {1'b0, inc};
    assign mv_t = sum[TIME_W] ? T_MAX : sum[TIME_W-1:0];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) mode_q <= 2'd0;
        else mode_q <= mode_d;
`else
    assign mv_t = cur_dec;
`endif

    always_comb begin
        state_d = state_q;
        act_d = act_q;
        loser_d = loser_q;
        time_up_d = time_up_q;
        time_d = time_q;
        if (bus.start) begin
            state_d = RUN;
            act_d = '0;
            loser_d = '0;
            time_up_d = 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) time_d[p] = preset;
        end else if (state_q == IDLE) begin
            for (int p = 0; p < N_PLAYERS; p++) time_d[p] = preset;
        end else if (run && expire) begin
            time_d[act_q] = '0;
            state_d = EXPIRED;
            time_up_d = 1'b1;
            loser_d = act_q;
        end else if (run) begin
            time_d[act_q] = bus.move_done ? mv_t : cur_dec;
            if (bus.move_done) act_d = act_q == PW'(N_PLAYERS - 1) ? '0 : act_q + 1'b1;
            if (bus.pause) state_d = PAUSED;
        end else if (state_q == PAUSED && bus.pause) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            act_q <= '0;
            loser_q <= '0;
            time_up_q <= 1'b0;
            time_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            act_q <= act_d;
            loser_q <= loser_d;
            time_up_q <= time_up_d;
            time_q <= time_d;
        end

    always_comb
        for (int p = 0; p < N_PLAYERS; p++) bus.time_cs[p*TIME_W +: TIME_W] = time_q[p];
    assign bus.active_player = act_q;
    assign bus.running = run;
    assign bus.time_up = time_up_q;
    assign bus.loser = loser_q;

    logic [TIME_W-1:0] shown, q_min, q_sec;
    logic [6:0] mins, secs, cents;
    logic [3:0] dig [6];
    logic [6:0] seg [6];
    assign shown = int'(bus.disp_sel) < N_PLAYERS ? time_q[bus.disp_sel] : '0;
    assign q_min = shown / TIME_W'(CS_PER_MIN);
    assign q_sec = shown / TIME_W'(CS_PER_SEC);
    assign mins = q_min > TIME_W'(99) ? 7'd99 : q_min[6:0];
    assign secs = 7'(q_sec % TIME_W'(60));
    assign cents = 7'(shown % TIME_W'(CS_PER_SEC));
    assign dig[0] = 4'(cents % 7'd10);
    assign dig[1] = 4'(cents / 7'd10);
    assign dig[2] = 4'(secs % 7'd10);
    assign dig[3] = 4'(secs / 7'd10);
    assign dig[4] = 4'(mins % 7'd10);
    assign dig[5] = 4'(mins / 7'd10);
    for (genvar g = 0; g < 6; g++) begin : g_hex
        hex_display u_hex (.val(dig[g]), .seg(seg[g]));
    end
    assign bus.hex0 = seg[0];
    assign bus.hex1 = seg[1];
    assign bus.hex2 = seg[2];
    assign bus.hex3 = seg[3];
    assign bus.hex4 = seg[4];
    assign bus.hex5 = seg[5];
endmodule
